mm_result_serializer: RTL

//   Downstream of the systolic-array MatrixMultiplier. Captures each completed set of four

---
 rtl/mm_result_serializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mm_result_serializer.sv
// mm_result_serializer
// Buffers completed four-element result sets from the matrix multiplier in a
// small FIFO and streams them out one element per valid/ready beat, element 0
// first, with out_last flagging element 3. Sets arriving while the FIFO is
// full are dropped and recorded in a sticky overflow flag.
module mm_result_serializer #(
  parameter int RES_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  input  logic [RES_W-1:0] res0,
  input  logic [RES_W-1:0] res1,
  input  logic [RES_W-1:0] res2,
  input  logic [RES_W-1:0] res3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [RES_W-1:0] out_data,
  output logic             out_last,
  output logic             in_ready,
  output logic             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SET_W = 4 * RES_W;

  logic [SET_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_idx;
  logic             r_overflow;

  logic             w_full;
  logic             w_valid;
  logic             w_push;
  logic             w_drop;
  logic             w_xfer;
  logic             w_pop;
  logic [SET_W-1:0] w_entry;
  logic [RES_W-1:0] w_elem;

  // Handshake decode; fullness is always judged on the pre-edge count so a
  // pop on the same edge cannot rescue a set that arrives while full.
  always_comb begin
    w_full  = (r_count == CNT_W'(DEPTH));
    w_valid = (r_count != {CNT_W{1'b0}});
    w_push  = res_valid & ~w_full;
    w_drop  = res_valid & w_full;
    w_xfer  = w_valid & out_ready;
    w_pop   = w_xfer & (r_idx == 2'd3);
  end

  // Select the element of the head set addressed by the beat index.
  always_comb begin
    w_entry = r_mem[r_rd_ptr];
    w_elem  = {RES_W{1'b0}};
    case (r_idx)
      2'd0:    w_elem = w_entry[0*RES_W +: RES_W];
      2'd1:    w_elem = w_entry[1*RES_W +: RES_W];
      2'd2:    w_elem = w_entry[2*RES_W +: RES_W];
      2'd3:    w_elem = w_entry[3*RES_W +: RES_W];
      default: w_elem = {RES_W{1'b0}};
    endcase
  end

  // Output decode: every output depends on registered state only.
  always_comb begin
    out_valid = w_valid;
    in_ready  = ~w_full;
    overflow  = r_overflow;
    if (w_valid) begin
      out_data = w_elem;
      out_last = (r_idx == 2'd3);
    end else begin
      out_data = {RES_W{1'b0}};
      out_last = 1'b0;
    end
  end

  // Set storage; contents are only observed while count is non-zero, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {res3, res2, res1, res0};
    end
  end

  // Pointer, occupancy, beat index and sticky overflow tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_idx      <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_xfer) begin
        if (r_idx == 2'd3) begin
          r_idx    <= 2'd0;
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
